// File: rtl/fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_ctrl
// Brief    : FIR engine sequencer: AXI-Stream in/out, circular sample history
//            in data BRAM, single MAC walked over the tap BRAM.
//            Optional build macro FIR_CTRL_PERF_CNT_EN enables cycle_cnt and
//            the sticky err_tlast framing flag.
// Revision : 1.0 - initial release
// ============================================================================
module fir_ctrl #(
    parameter int NUM_TAPS = 11,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ap_start,
    input  logic [31:0]       data_length,
    output logic              ap_done,
    output logic              ap_idle,
    output logic [31:0]       cycle_cnt,
    input  logic              ss_tvalid,
    input  logic [DATA_W-1:0] ss_tdata,
    input  logic              ss_tlast,
    output logic              ss_tready,
    output logic              sm_tvalid,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast,
    input  logic              sm_tready,
    output logic              tap_EN,
    output logic [ADDR_W-1:0] tap_A,
    input  logic [DATA_W-1:0] tap_Do,
    output logic              data_EN,
    output logic [3:0]        data_WE,
    output logic [ADDR_W-1:0] data_A,
    output logic [DATA_W-1:0] data_Di,
    input  logic [DATA_W-1:0] data_Do,
    output logic              err_tlast
);

    localparam int                 c_IDX_W    = $clog2(NUM_TAPS + 1);
    localparam logic [c_IDX_W-1:0] c_NUM      = c_IDX_W'(NUM_TAPS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_WAIT_IN = 3'd2,
        S_MAC     = 3'd3,
        S_OUT     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_k;
    logic [c_IDX_W-1:0]  r_head;
    logic                r_rd_vld;
    logic [31:0]         r_len;
    logic [31:0]         r_count;
    logic [DATA_W-1:0]   r_acc;

    logic [DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]   w_acc_sum;
    logic [c_IDX_W-1:0]  w_hist_idx;
    logic                w_is_final;

    assign w_prod     = tap_Do * data_Do;
    assign w_acc_sum  = r_acc + w_prod;
    assign w_is_final = (r_count == (r_len - 32'd1));
    // (head - k) mod NUM_TAPS; the wrapped sum always fits c_IDX_W bits
    assign w_hist_idx = (r_head >= r_k) ? (r_head - r_k) : (r_head + c_NUM - r_k);

    always_comb begin
        ss_tready = (r_state == S_WAIT_IN);
        tap_EN    = 1'b0;
        tap_A     = '0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        data_Di   = '0;
        case (r_state)
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = ADDR_W'(r_k) << 2;
            end
            S_WAIT_IN: begin
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = ADDR_W'(r_head) << 2;
                    data_Di = ss_tdata;
                end
            end
            S_MAC: begin
                if (r_k < c_NUM) begin
                    tap_EN  = 1'b1;
                    tap_A   = ADDR_W'(r_k) << 2;
                    data_EN = 1'b1;
                    data_A  = ADDR_W'(w_hist_idx) << 2;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            ap_idle   <= 1'b1;
            ap_done   <= 1'b0;
            sm_tvalid <= 1'b0;
            sm_tdata  <= '0;
            sm_tlast  <= 1'b0;
            r_k       <= '0;
            r_head    <= '0;
            r_rd_vld  <= 1'b0;
            r_len     <= '0;
            r_count   <= '0;
            r_acc     <= '0;
        end else begin
            ap_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_state <= S_CLEAR;
                        ap_idle <= 1'b0;
                        r_len   <= data_length;
                        r_k     <= '0;
                        r_head  <= '0;
                        r_count <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_k == c_LAST_IDX) begin
                        r_k <= '0;
                        if (r_len == 32'd0) begin
                            r_state <= S_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_IN;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_WAIT_IN: begin
                    if (ss_tvalid) begin
                        r_state  <= S_MAC;
                        r_k      <= '0;
                        r_rd_vld <= 1'b0;
                        r_acc    <= '0;
                    end
                end
                S_MAC: begin
                    // read data lags the address by one cycle, so the last
                    // product lands in the extra k == NUM_TAPS cycle
                    r_rd_vld <= (r_k < c_NUM);
                    if (r_rd_vld) begin
                        r_acc <= w_acc_sum;
                    end
                    if (r_k == c_NUM) begin
                        r_state   <= S_OUT;
                        sm_tvalid <= 1'b1;
                        sm_tdata  <= w_acc_sum;
                        sm_tlast  <= w_is_final;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_OUT: begin
                    if (sm_tready) begin
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        r_head    <= (r_head == c_LAST_IDX) ? '0 : r_head + 1'b1;
                        r_count   <= r_count + 32'd1;
                        if ((r_count + 32'd1) == r_len) begin
                            r_state <= S_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_IN;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    ap_idle <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FIR_CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic        r_err_tlast;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cycle_cnt <= '0;
            r_err_tlast <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (ap_start) begin
                r_cycle_cnt <= '0;
                r_err_tlast <= 1'b0;
            end
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if ((r_state == S_WAIT_IN) && ss_tvalid && (ss_tlast != w_is_final)) begin
                r_err_tlast <= 1'b1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign err_tlast = r_err_tlast;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = ss_tlast;
    assign cycle_cnt      = '0;
    assign err_tlast      = 1'b0;
`endif

endmodule
`default_nettype wire
